// File: rtl/timing_generator.sv
// -----------------------------------------------------------------------------
// timing_generator
//
// Cycle timing generator for the 6502 core. It produces the per-instruction
// T-state (CYCLE) that the decode ROM uses to time register strobes. It also
// owns reset sequencing, RDY stalls, NMI edge capture, IRQ qualification and
// forced-BRK interrupt entry, and it drives the vector select.
//
// Ports:
//   CLK            core clock; all state changes on the rising edge
//   RST            synchronous, active-high reset
//   RDY            ready; low stalls read cycles only
//   RW             current bus direction from decode, 1 = read
//   LAST_CYCLE     decode flag: current cycle is the instruction's final cycle
//   NMI_N          non-maskable interrupt, falling-edge sensitive (synchronised)
//   IRQ_N          maskable interrupt, level sensitive, active low
//   I_FLAG         PSR interrupt-disable bit
//   CYCLE          current T-state, 0 = opcode fetch cycle
//   SYNC           opcode fetch cycle of a normal instruction (combinational)
//   STALL          cycle frozen by RDY (combinational)
//   RESET_SEQ      reset sequence active
//   INT_SEQ        forced-BRK interrupt sequence active; IR loads 0x00
//   PC_INC_INHIBIT suppress PC increment
//   VEC_SEL        00 none, 01 IRQ/BRK FFFE, 10 NMI FFFA, 11 reset FFFC
//   CYCLE_OVF      one-clock pulse when CYCLE is forced to wrap
//
// Outputs other than SYNC and STALL are registered: every one of them is
// computed from the next-state values and loaded on the clock edge.
// -----------------------------------------------------------------------------
module timing_generator #(
  parameter int MAX_CYCLE    = 7,
  parameter int RESET_CYCLES = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RDY,
  input  logic       RW,
  input  logic       LAST_CYCLE,
  input  logic       NMI_N,
  input  logic       IRQ_N,
  input  logic       I_FLAG,
  output logic [2:0] CYCLE,
  output logic       SYNC,
  output logic       STALL,
  output logic       RESET_SEQ,
  output logic       INT_SEQ,
  output logic       PC_INC_INHIBIT,
  output logic [1:0] VEC_SEL,
  output logic       CYCLE_OVF
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RESET_RUN  = 2'd1,
    RUN        = 2'd2
  } state_t;

  localparam logic [2:0] CYC_MAX     = 3'(MAX_CYCLE);
  localparam logic [2:0] RST_LAST    = 3'(RESET_CYCLES - 1);
  // The final two reset cycles fetch the reset vector, so the PC is allowed
  // to be loaded/incremented there.
  localparam logic [2:0] RST_PC_LAST = 3'(RESET_CYCLES - 3);

  localparam logic [1:0] VEC_NONE  = 2'b00;
  localparam logic [1:0] VEC_IRQ   = 2'b01;
  localparam logic [1:0] VEC_NMI   = 2'b10;
  localparam logic [1:0] VEC_RESET = 2'b11;

  state_t     state;
  state_t     state_nx;
  logic [2:0] cycle_nx;
  logic       int_seq_nx;
  logic [1:0] vec_sel_nx;
  logic       pc_inc_nx;
  logic       ovf_nx;
  logic       nmi_pending;
  logic       nmi_pending_nx;
  logic       nmi_prev;
  logic       nmi_prev_nx;
  logic       advance;
  logic       wrap;
  logic       boundary;
  logic       nmi_edge;
  logic       irq_req;
  logic       take_nmi;

  // Next-state and combinational outputs.
  always_comb begin
    state_nx       = state;
    cycle_nx       = CYCLE;
    int_seq_nx     = INT_SEQ;
    vec_sel_nx     = VEC_SEL;
    pc_inc_nx      = PC_INC_INHIBIT;
    ovf_nx         = 1'b0;
    nmi_prev_nx    = nmi_prev;
    nmi_pending_nx = nmi_pending;
    advance        = RDY | ~RW;   // RDY only freezes read cycles
    wrap           = 1'b0;
    boundary       = 1'b0;
    take_nmi       = 1'b0;
    irq_req        = ~IRQ_N & ~I_FLAG;
    nmi_edge       = 1'b0;
    STALL          = 1'b0;
    SYNC           = 1'b0;

    // NMI history is tracked every clock (stalled or not) once out of hold.
    if (state != RESET_HOLD) begin
      nmi_edge    = nmi_prev & ~NMI_N;
      nmi_prev_nx = NMI_N;
    end

    case (state)
      RESET_HOLD: begin
        state_nx   = RESET_RUN;
        cycle_nx   = 3'd0;
        int_seq_nx = 1'b0;
        vec_sel_nx = VEC_RESET;
        pc_inc_nx  = 1'b1;
      end

      RESET_RUN: begin
        if (CYCLE == RST_LAST) begin
          state_nx   = RUN;
          cycle_nx   = 3'd0;
          vec_sel_nx = VEC_NONE;
          pc_inc_nx  = 1'b0;
        end else begin
          cycle_nx  = CYCLE + 3'd1;
          pc_inc_nx = (CYCLE + 3'd1) <= RST_PC_LAST;
        end
      end

      RUN: begin
        STALL = ~advance;
        SYNC  = (CYCLE == 3'd0) & ~INT_SEQ;
        if (advance) begin
          wrap     = ~LAST_CYCLE & (CYCLE == CYC_MAX);
          boundary = LAST_CYCLE | wrap;
          ovf_nx   = wrap;
          if (boundary) begin
            cycle_nx = 3'd0;
            // Interrupts are only recognised here, so an NMI arriving during
            // an IRQ sequence waits for that sequence to finish.
            if (nmi_pending) begin
              take_nmi   = 1'b1;
              int_seq_nx = 1'b1;
              vec_sel_nx = VEC_NMI;
            end else if (irq_req) begin
              int_seq_nx = 1'b1;
              vec_sel_nx = VEC_IRQ;
            end else begin
              int_seq_nx = 1'b0;
              vec_sel_nx = VEC_NONE;
            end
          end else begin
            cycle_nx = CYCLE + 3'd1;
          end
          pc_inc_nx = int_seq_nx & (cycle_nx <= 3'd1);
        end
      end

      default: begin
        state_nx = RESET_HOLD;
      end
    endcase

    // A fresh edge on the clearing clock survives the clear.
    nmi_pending_nx = nmi_edge | (nmi_pending & ~take_nmi);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= RESET_HOLD;
      CYCLE          <= 3'd0;
      RESET_SEQ      <= 1'b1;
      VEC_SEL        <= VEC_RESET;
      PC_INC_INHIBIT <= 1'b1;
      INT_SEQ        <= 1'b0;
      CYCLE_OVF      <= 1'b0;
      nmi_pending    <= 1'b0;
      nmi_prev       <= 1'b1;
    end else begin
      state          <= state_nx;
      CYCLE          <= cycle_nx;
      RESET_SEQ      <= (state_nx != RUN);
      VEC_SEL        <= vec_sel_nx;
      PC_INC_INHIBIT <= pc_inc_nx;
      INT_SEQ        <= int_seq_nx;
      CYCLE_OVF      <= ovf_nx;
      nmi_pending    <= nmi_pending_nx;
      nmi_prev       <= nmi_prev_nx;
    end
  end

endmodule

// File: tb/tb_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_timing_generator
//
// Directed walk through reset, plain instructions, stalls, IRQ masking, NMI
// priority, forced wrap and mid-sequence reset, followed by a randomized run.
// Every clock all outputs are compared with a behavioural model that tracks
// "clocks since reset released", the T-state as an integer and the kind of
// interrupt being served.
// -----------------------------------------------------------------------------
module tb_timing_generator;

  localparam int RESET_LEN = 7;   // clocks of reset sequence
  localparam int CYC_MAX   = 7;
  localparam int K_NONE    = 0;
  localparam int K_IRQ     = 1;
  localparam int K_NMI     = 2;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rdy, rw, last_cycle, nmi_n, irq_n, i_flag;
  logic [2:0] cycle;
  logic       sync, stall, reset_seq, int_seq, pc_inc_inhibit, cycle_ovf;
  logic [1:0] vec_sel;

  timing_generator dut (
    .CLK            (clk),
    .RST            (rst),
    .RDY            (rdy),
    .RW             (rw),
    .LAST_CYCLE     (last_cycle),
    .NMI_N          (nmi_n),
    .IRQ_N          (irq_n),
    .I_FLAG         (i_flag),
    .CYCLE          (cycle),
    .SYNC           (sync),
    .STALL          (stall),
    .RESET_SEQ      (reset_seq),
    .INT_SEQ        (int_seq),
    .PC_INC_INHIBIT (pc_inc_inhibit),
    .VEC_SEL        (vec_sel),
    .CYCLE_OVF      (cycle_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model
  bit m_valid = 0;
  int m_age;        // -1 while held in reset, 0..6 reset run, 7 running
  int m_cyc;
  int m_kind;
  bit m_pend;
  bit m_nmi_last;
  bit m_ovf;

  function automatic logic [1:0] vec_of(input int kind);
    logic [1:0] tbl [3];
    tbl[0] = 2'b00;
    tbl[1] = 2'b01;
    tbl[2] = 2'b10;
    return tbl[kind];
  endfunction

  task automatic model_clock();
    bit edge_seen;
    bit adv;
    bit wrap;
    edge_seen = 0;
    if (rst) begin
      m_valid = 1; m_age = -1; m_cyc = 0; m_kind = K_NONE;
      m_pend = 0; m_nmi_last = 1; m_ovf = 0;
      return;
    end
    if (m_age != -1) begin
      edge_seen = m_nmi_last && !nmi_n;
      m_nmi_last = nmi_n;
    end
    m_ovf = 0;
    if (m_age < RESET_LEN) begin
      m_age = m_age + 1;
      m_cyc = (m_age == RESET_LEN) ? 0 : m_age;
      m_kind = K_NONE;
    end else begin
      adv = rdy || !rw;
      if (adv) begin
        wrap = !last_cycle && (m_cyc == CYC_MAX);
        if (last_cycle || wrap) begin
          m_cyc = 0;
          m_ovf = wrap;
          if (m_pend) begin
            m_kind = K_NMI;
            m_pend = 0;
          end else if (!irq_n && !i_flag) begin
            m_kind = K_IRQ;
          end else begin
            m_kind = K_NONE;
          end
        end else begin
          m_cyc = m_cyc + 1;
        end
      end
    end
    if (edge_seen) m_pend = 1;
  endtask

  // scoreboard compare
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string where);
    bit running;
    running = (m_age == RESET_LEN);
    chk({where, ".stall"}, {7'd0, stall}, {7'd0, running && !rdy && rw});
    chk({where, ".sync"},  {7'd0, sync},  {7'd0, running && m_cyc == 0 && m_kind == K_NONE});
  endtask

  task automatic check_all(input string where);
    bit running;
    bit exp_pc;
    running = (m_age == RESET_LEN);
    exp_pc = running ? (m_kind != K_NONE && m_cyc <= 1) : (m_cyc <= RESET_LEN - 3);
    chk({where, ".cycle"},     {5'd0, cycle},     8'(m_cyc));
    chk({where, ".reset_seq"}, {7'd0, reset_seq}, {7'd0, !running});
    chk({where, ".int_seq"},   {7'd0, int_seq},   {7'd0, m_kind != K_NONE});
    chk({where, ".vec_sel"},   {6'd0, vec_sel},   {6'd0, running ? vec_of(m_kind) : 2'b11});
    chk({where, ".pc_inh"},    {7'd0, pc_inc_inhibit}, {7'd0, exp_pc});
    chk({where, ".ovf"},       {7'd0, cycle_ovf}, {7'd0, m_ovf});
    check_comb(where);
  endtask

  // driver: inputs are set after a falling edge; one call = one rising edge
  task automatic tick(input string where);
    #1;
    if (m_valid) check_comb({where, ".pre"});
    @(posedge clk);
    model_clock();
    #1;
    check_all(where);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; rdy = 1; rw = 1; last_cycle = 0;
    nmi_n = 1; irq_n = 1; i_flag = 1;

    // reset held for 3 clocks
    repeat (3) tick("rst_hold");
    chk("rst.cycle", {5'd0, cycle}, 8'd0);
    chk("rst.vec", {6'd0, vec_sel}, 8'd3);
    chk("rst.pc_inh", {7'd0, pc_inc_inhibit}, 8'd1);

    // reset sequence; RDY low/read must not stall it
    rst = 0; rdy = 0;
    for (int i = 0; i < RESET_LEN; i++) begin
      tick("rst_run");
      chk("rst_run.cycle", {5'd0, cycle}, 8'(i));
      chk("rst_run.seq", {7'd0, reset_seq}, 8'd1);
    end
    rdy = 1;
    tick("rst_exit");
    chk("rst_exit.sync", {7'd0, sync}, 8'd1);
    chk("rst_exit.seq", {7'd0, reset_seq}, 8'd0);

    // 3-cycle instruction
    last_cycle = 0; tick("ins3");
    last_cycle = 0; tick("ins3");
    chk("ins3.c2", {5'd0, cycle}, 8'd2);
    last_cycle = 1; tick("ins3");
    chk("ins3.c0", {5'd0, cycle}, 8'd0);
    chk("ins3.sync", {7'd0, sync}, 8'd1);

    // stall on read, no stall on write
    last_cycle = 0; tick("stall");
    rdy = 0; rw = 1;
    tick("stall"); tick("stall");
    chk("stall.hold", {5'd0, cycle}, 8'd1);
    rw = 0; tick("nostall");
    chk("nostall.cycle", {5'd0, cycle}, 8'd2);
    rdy = 1; rw = 1; last_cycle = 1; tick("stall_end");

    // IRQ masked, then unmasked
    irq_n = 0; i_flag = 1; tick("irq_mask");
    chk("irq_mask.int", {7'd0, int_seq}, 8'd0);
    i_flag = 0; tick("irq_take");
    chk("irq_take.vec", {6'd0, vec_sel}, 8'd1);
    chk("irq_take.sync", {7'd0, sync}, 8'd0);
    irq_n = 1; last_cycle = 0; tick("irq_seq");
    chk("irq_seq.pc_c1", {7'd0, pc_inc_inhibit}, 8'd1);
    tick("irq_seq");
    last_cycle = 1; tick("irq_done");
    chk("irq_done.int", {7'd0, int_seq}, 8'd0);

    // NMI beats IRQ; second NMI during the sequence served next
    last_cycle = 0; tick("nmi");
    nmi_n = 0; irq_n = 0; tick("nmi");
    last_cycle = 1; tick("nmi_take");
    chk("nmi_take.vec", {6'd0, vec_sel}, 8'd2);
    nmi_n = 1; irq_n = 1; last_cycle = 0; tick("nmi_seq");
    nmi_n = 0; tick("nmi_seq");
    last_cycle = 1; tick("nmi_take2");
    chk("nmi_take2.vec", {6'd0, vec_sel}, 8'd2);
    nmi_n = 1; tick("nmi_done");
    chk("nmi_done.int", {7'd0, int_seq}, 8'd0);

    // forced wrap
    last_cycle = 0;
    repeat (7) tick("wrap");
    chk("wrap.c7", {5'd0, cycle}, 8'd7);
    tick("wrap");
    chk("wrap.ovf", {7'd0, cycle_ovf}, 8'd1);
    last_cycle = 1; tick("wrap_after");

    // reset in the middle of an interrupt sequence
    irq_n = 0; i_flag = 0; tick("rst_mid");
    irq_n = 1; last_cycle = 0;
    repeat (4) tick("rst_mid");
    rst = 1; tick("rst_mid_hit");
    chk("rst_mid.int", {7'd0, int_seq}, 8'd0);
    chk("rst_mid.vec", {6'd0, vec_sel}, 8'd3);
    rst = 0; i_flag = 1;
    repeat (RESET_LEN + 1) tick("rst_mid_rerun");

    // randomized run
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rdy        = ($urandom_range(0, 3) != 0);
      rw         = $urandom_range(0, 1);
      last_cycle = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      irq_n      = ($urandom_range(0, 3) != 0);
      i_flag     = $urandom_range(0, 1);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
